// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch controller.
// Digit indices follow bcd_in packing {mt,mu,st,su}.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_SET   = 2'd3
  } sw_state_t;

  localparam int DIG_SU = 0;
  localparam int DIG_ST = 1;
  localparam int DIG_MU = 2;
  localparam int DIG_MT = 3;

  localparam logic [3:0] UNIT_MAX = 4'd9;

  localparam int NBTN    = 5;
  localparam int BTN_INC = 0;
  localparam int BTN_LAP = 1;
  localparam int BTN_SS  = 2;
  localparam int BTN_MOD = 3;
  localparam int BTN_CLR = 4;

  function automatic logic [3:0] next_digit(
    input logic [3:0] cur,
    input logic [3:0] term
  );
    return (cur == term) ? 4'd0 : cur + 4'd1;
  endfunction

endpackage

// File: rtl/sw_btn_edge.sv
// Rising-edge press detector for one debounced button level.
// A level already high when reset releases is never a press.
module sw_btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic prev_q, prev_d;
  logic armed_q, armed_d;

  always_comb begin
    prev_d  = btn;
    armed_d = 1'b1;
  end

  // armed_q stays low for the first edge so prev_q learns the held level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign press = armed_q & btn & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: run/pause/set, carry cascade,
// digit set-loading, lap hold and overflow flag.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int SEC_TENS_MAX = 5,
  parameter int MIN_TENS_MAX = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        btn_ss,
  input  logic        btn_lap,
  input  logic        btn_clr,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [3:0]  tc,
  input  logic [15:0] bcd_in,
  output logic [3:0]  cnt_en,
  output logic [3:0]  load,
  output logic [3:0]  load_val,
  output logic        clear,
  output logic [15:0] disp,
  output logic [3:0]  sel,
  output logic [1:0]  state,
  output logic        ovf
);

  localparam logic [3:0] ST_MAX = 4'(SEC_TENS_MAX);
  localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

  logic [NBTN-1:0] btn_lvl;
  logic [NBTN-1:0] btn_press;

  assign btn_lvl[BTN_INC] = btn_inc;
  assign btn_lvl[BTN_LAP] = btn_lap;
  assign btn_lvl[BTN_SS]  = btn_ss;
  assign btn_lvl[BTN_MOD] = btn_mode;
  assign btn_lvl[BTN_CLR] = btn_clr;

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    sw_btn_edge u_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_lvl[i]),
      .press (btn_press[i])
    );
  end

  logic p_clr, p_mode, p_ss, p_lap, p_inc;

  // only the highest-priority press survives
  always_comb begin
    p_clr  = 1'b0;
    p_mode = 1'b0;
    p_ss   = 1'b0;
    p_lap  = 1'b0;
    p_inc  = 1'b0;
    if (btn_press[BTN_CLR])      p_clr  = 1'b1;
    else if (btn_press[BTN_MOD]) p_mode = 1'b1;
    else if (btn_press[BTN_SS])  p_ss   = 1'b1;
    else if (btn_press[BTN_LAP]) p_lap  = 1'b1;
    else if (btn_press[BTN_INC]) p_inc  = 1'b1;
  end

  sw_state_t   state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  cnt_en_q, cnt_en_d;
  logic [3:0]  load_q, load_d;
  logic [3:0]  load_val_q, load_val_d;
  logic        clear_q, clear_d;
  logic        ovf_q, ovf_d;
  logic        lap_hold_q, lap_hold_d;
  logic [15:0] lap_reg_q, lap_reg_d;

  logic [3:0] cur_dig;
  logic [3:0] term_dig;

  always_comb begin
    cur_dig  = 4'd0;
    term_dig = UNIT_MAX;
    unique case (1'b1)
      sel_q[DIG_SU]: begin
        cur_dig  = bcd_in[3:0];
        term_dig = UNIT_MAX;
      end
      sel_q[DIG_ST]: begin
        cur_dig  = bcd_in[7:4];
        term_dig = ST_MAX;
      end
      sel_q[DIG_MU]: begin
        cur_dig  = bcd_in[11:8];
        term_dig = UNIT_MAX;
      end
      sel_q[DIG_MT]: begin
        cur_dig  = bcd_in[15:12];
        term_dig = MT_MAX;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ovf_d      = ovf_q;
    lap_hold_d = lap_hold_q;
    lap_reg_d  = lap_reg_q;
    cnt_en_d   = 4'd0;
    load_d     = 4'd0;
    load_val_d = 4'd0;
    clear_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (p_ss) begin
          state_d = S_RUN;
        end else if (p_mode) begin
          state_d = S_SET;
          sel_d   = 4'b0001;
        end else if (p_clr) begin
          clear_d    = 1'b1;
          ovf_d      = 1'b0;
          lap_hold_d = 1'b0;
        end
      end
      S_RUN: begin
        if (tick) begin
          cnt_en_d = {&tc[2:0], &tc[1:0], tc[0], 1'b1};
          if (&tc) ovf_d = 1'b1;
        end
        if (p_ss) begin
          state_d = S_PAUSE;
        end else if (p_lap) begin
          lap_hold_d = ~lap_hold_q;
          if (!lap_hold_q) lap_reg_d = bcd_in;
        end
      end
      S_PAUSE: begin
        if (p_ss) begin
          state_d = S_RUN;
        end else if (p_clr) begin
          state_d    = S_IDLE;
          clear_d    = 1'b1;
          ovf_d      = 1'b0;
          lap_hold_d = 1'b0;
        end else if (p_mode) begin
          state_d = S_SET;
          sel_d   = 4'b0001;
        end
      end
      S_SET: begin
        if (p_mode) begin
          if (sel_q[DIG_MT]) begin
            state_d = S_PAUSE;
            sel_d   = 4'd0;
          end else begin
            sel_d = sel_q << 1;
          end
        end else if (p_inc) begin
          load_d     = sel_q;
          load_val_d = next_digit(cur_dig, term_dig);
        end else if (p_clr) begin
          state_d    = S_IDLE;
          sel_d      = 4'd0;
          clear_d    = 1'b1;
          ovf_d      = 1'b0;
          lap_hold_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= 4'd0;
      cnt_en_q   <= 4'd0;
      load_q     <= 4'd0;
      load_val_q <= 4'd0;
      clear_q    <= 1'b0;
      ovf_q      <= 1'b0;
      lap_hold_q <= 1'b0;
      lap_reg_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_en_q   <= cnt_en_d;
      load_q     <= load_d;
      load_val_q <= load_val_d;
      clear_q    <= clear_d;
      ovf_q      <= ovf_d;
      lap_hold_q <= lap_hold_d;
      lap_reg_q  <= lap_reg_d;
    end
  end

  assign cnt_en   = cnt_en_q;
  assign load     = load_q;
  assign load_val = load_val_q;
  assign clear    = clear_q;
  assign sel      = sel_q;
  assign state    = state_q;
  assign ovf      = ovf_q;
  assign disp     = lap_hold_q ? lap_reg_q : bcd_in;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a queue of
// expected output snapshots checked after each edge.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic        btn_ss, btn_lap, btn_clr;
  logic        btn_mode, btn_inc;
  logic [3:0]  tc;
  logic [15:0] bcd_in;
  logic [3:0]  cnt_en, load, load_val, sel;
  logic        clear, ovf;
  logic [15:0] disp;
  logic [1:0]  state;

  stopwatch_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .btn_ss   (btn_ss),
    .btn_lap  (btn_lap),
    .btn_clr  (btn_clr),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .tc       (tc),
    .bcd_in   (bcd_in),
    .cnt_en   (cnt_en),
    .load     (load),
    .load_val (load_val),
    .clear    (clear),
    .disp     (disp),
    .sel      (sel),
    .state    (state),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] B0  = 5'b00000;
  localparam logic [4:0] BCL = 5'b10000;
  localparam logic [4:0] BMO = 5'b01000;
  localparam logic [4:0] BSS = 5'b00100;
  localparam logic [4:0] BLP = 5'b00010;
  localparam logic [4:0] BIN = 5'b00001;

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic [3:0]  sel;
    logic [3:0]  cnt;
    logic [3:0]  ld;
    logic [3:0]  lv;
    logic        clr;
    logic        ovf;
    logic [15:0] disp;
  } exp_t;

  exp_t sb[$];
  int   npass = 0;
  int   nfail = 0;
  int   ntot  = 0;

  task automatic chk(input string tag, input string f,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s.%s got %h exp %h", tag, f, got, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      ntot++;
      nfail++;
      $display("FAIL sb_empty got 0 exp 1");
      return;
    end
    e = sb.pop_front();
    chk(e.tag, "state", 16'(state), 16'(e.st));
    chk(e.tag, "sel", 16'(sel), 16'(e.sel));
    chk(e.tag, "cnt_en", 16'(cnt_en), 16'(e.cnt));
    chk(e.tag, "load", 16'(load), 16'(e.ld));
    chk(e.tag, "load_val", 16'(load_val), 16'(e.lv));
    chk(e.tag, "clear", 16'(clear), 16'(e.clr));
    chk(e.tag, "ovf", 16'(ovf), 16'(e.ovf));
    chk(e.tag, "disp", disp, e.disp);
  endtask

  task automatic push(input string tag, input logic [1:0] es,
                      input logic [3:0] esel, input logic [3:0] ecnt,
                      input logic [3:0] eld, input logic [3:0] elv,
                      input logic eclr, input logic eovf,
                      input logic [15:0] edisp);
    exp_t e;
    e.tag = tag;  e.st = es;   e.sel = esel; e.cnt = ecnt;
    e.ld = eld;   e.lv = elv;  e.clr = eclr; e.ovf = eovf;
    e.disp = edisp;
    sb.push_back(e);
  endtask

  task automatic step(input string tag, input logic [4:0] b,
                      input logic tk, input logic [3:0] tcv,
                      input logic [15:0] bcd,
                      input logic [1:0] es, input logic [3:0] esel,
                      input logic [3:0] ecnt, input logic [3:0] eld,
                      input logic [3:0] elv, input logic eclr,
                      input logic eovf, input logic [15:0] edisp);
    @(negedge clk);
    {btn_clr, btn_mode, btn_ss, btn_lap, btn_inc} = b;
    tick   = tk;
    tc     = tcv;
    bcd_in = bcd;
    push(tag, es, esel, ecnt, eld, elv, eclr, eovf, edisp);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {btn_clr, btn_mode, btn_ss, btn_lap, btn_inc} = B0;
    tick   = 1'b0;
    tc     = 4'd0;
    bcd_in = 16'h1234;
    #3;
    push("rst", 0, 0, 0, 0, 0, 0, 0, 16'h1234);
    pop_check();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    bcd_in = 16'h0000;

    step("idle0",  B0,  0, 4'h0, 16'h0000, 0, 0, 4'h0, 0, 0, 0, 0, 16'h0000);
    step("idle1",  B0,  0, 4'h0, 16'h0000, 0, 0, 4'h0, 0, 0, 0, 0, 16'h0000);
    step("ss_idle",BSS, 0, 4'h0, 16'h0000, 1, 0, 4'h0, 0, 0, 0, 0, 16'h0000);
    step("tick0",  B0,  1, 4'h0, 16'h0000, 1, 0, 4'h1, 0, 0, 0, 0, 16'h0000);
    step("pulse1", B0,  0, 4'h0, 16'h0000, 1, 0, 4'h0, 0, 0, 0, 0, 16'h0000);
    step("tc0001", B0,  1, 4'h1, 16'h0000, 1, 0, 4'h3, 0, 0, 0, 0, 16'h0000);
    step("tc0010", B0,  1, 4'h2, 16'h0000, 1, 0, 4'h1, 0, 0, 0, 0, 16'h0000);
    step("tc0111", B0,  1, 4'h7, 16'h0000, 1, 0, 4'hf, 0, 0, 0, 0, 16'h0000);
    step("tc1111", B0,  1, 4'hf, 16'h0000, 1, 0, 4'hf, 0, 0, 0, 1, 16'h0000);
    step("ovf_hd", B0,  0, 4'h0, 16'h0000, 1, 0, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("clr_run",BCL, 0, 4'h0, 16'h0000, 1, 0, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("rel",    B0,  0, 4'h0, 16'h0000, 1, 0, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("mod_run",BMO, 0, 4'h0, 16'h0000, 1, 0, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("rel",    B0,  0, 4'h0, 16'h0000, 1, 0, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("lap1",   BLP, 0, 4'h0, 16'h0123, 1, 0, 4'h0, 0, 0, 0, 1, 16'h0123);
    step("lap_hd", B0,  0, 4'h0, 16'h0130, 1, 0, 4'h0, 0, 0, 0, 1, 16'h0123);
    step("lap2",   BLP, 0, 4'h0, 16'h0130, 1, 0, 4'h0, 0, 0, 0, 1, 16'h0130);
    step("live",   B0,  0, 4'h0, 16'h0145, 1, 0, 4'h0, 0, 0, 0, 1, 16'h0145);
    step("ss_run", BSS, 0, 4'h0, 16'h0000, 2, 0, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("tk_paus",B0,  1, 4'h0, 16'h0000, 2, 0, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("mod_pau",BMO, 0, 4'h0, 16'h0009, 3, 1, 4'h0, 0, 0, 0, 1, 16'h0009);
    step("rel",    B0,  0, 4'h0, 16'h0009, 3, 1, 4'h0, 0, 0, 0, 1, 16'h0009);
    step("inc_su9",BIN, 0, 4'h0, 16'h0009, 3, 1, 4'h0, 1, 0, 0, 1, 16'h0009);
    step("ld_puls",B0,  0, 4'h0, 16'h0009, 3, 1, 4'h0, 0, 0, 0, 1, 16'h0009);
    step("mode_s1",BMO, 0, 4'h0, 16'h0000, 3, 2, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("rel",    B0,  0, 4'h0, 16'h0000, 3, 2, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("inc_st3",BIN, 0, 4'h0, 16'h0030, 3, 2, 4'h0, 2, 4, 0, 1, 16'h0030);
    step("rel",    B0,  0, 4'h0, 16'h0030, 3, 2, 4'h0, 0, 0, 0, 1, 16'h0030);
    step("inc_st5",BIN, 0, 4'h0, 16'h0050, 3, 2, 4'h0, 2, 0, 0, 1, 16'h0050);
    step("rel",    B0,  0, 4'h0, 16'h0000, 3, 2, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("mode_s2",BMO, 0, 4'h0, 16'h0000, 3, 4, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("rel",    B0,  0, 4'h0, 16'h0000, 3, 4, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("inc_mu8",BIN, 0, 4'h0, 16'h0800, 3, 4, 4'h0, 4, 9, 0, 1, 16'h0800);
    step("rel",    B0,  0, 4'h0, 16'h0000, 3, 4, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("mode_s3",BMO, 0, 4'h0, 16'h0000, 3, 8, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("rel",    B0,  0, 4'h0, 16'h0000, 3, 8, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("inc_mt5",BIN, 0, 4'h0, 16'h5000, 3, 8, 4'h0, 8, 0, 0, 1, 16'h5000);
    step("rel",    B0,  0, 4'h0, 16'h0000, 3, 8, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("inc_mt2",BIN, 0, 4'h0, 16'h2000, 3, 8, 4'h0, 8, 3, 0, 1, 16'h2000);
    step("rel",    B0,  0, 4'h0, 16'h0000, 3, 8, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("ss_set", BSS, 1, 4'h0, 16'h0000, 3, 8, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("rel",    B0,  0, 4'h0, 16'h0000, 3, 8, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("mode_s4",BMO, 0, 4'h0, 16'h0000, 2, 0, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("rel",    B0,  0, 4'h0, 16'h0000, 2, 0, 4'h0, 0, 0, 0, 1, 16'h0000);
    step("clr_ss", BCL|BSS, 0, 4'h0, 16'h0000,
         0, 0, 4'h0, 0, 0, 1, 0, 16'h0000);
    step("clr_pul",B0,  0, 4'h0, 16'h0000, 0, 0, 4'h0, 0, 0, 0, 0, 16'h0000);
    step("tk_idle",B0,  1, 4'h0, 16'h0000, 0, 0, 4'h0, 0, 0, 0, 0, 16'h0000);
    step("clr_idl",BCL, 0, 4'h0, 16'h0000, 0, 0, 4'h0, 0, 0, 1, 0, 16'h0000);
    step("rel",    B0,  0, 4'h0, 16'h0000, 0, 0, 4'h0, 0, 0, 0, 0, 16'h0000);
    step("prio_ms",BMO|BSS, 0, 4'h0, 16'h0000,
         3, 1, 4'h0, 0, 0, 0, 0, 16'h0000);
    step("rel",    B0,  0, 4'h0, 16'h0000, 3, 1, 4'h0, 0, 0, 0, 0, 16'h0000);
    step("clr_set",BCL, 0, 4'h0, 16'h0000, 0, 0, 4'h0, 0, 0, 1, 0, 16'h0000);
    step("rel",    B0,  0, 4'h0, 16'h0000, 0, 0, 4'h0, 0, 0, 0, 0, 16'h0000);
    step("ss_idl2",BSS, 0, 4'h0, 16'h0000, 1, 0, 4'h0, 0, 0, 0, 0, 16'h0000);
    step("no_que", B0,  0, 4'h0, 16'h0000, 1, 0, 4'h0, 0, 0, 0, 0, 16'h0000);
    step("lap3",   BLP, 0, 4'h0, 16'h0222, 1, 0, 4'h0, 0, 0, 0, 0, 16'h0222);
    step("lap3_hd",B0,  0, 4'h0, 16'h0300, 1, 0, 4'h0, 0, 0, 0, 0, 16'h0222);
    step("ss_pau2",BSS, 0, 4'h0, 16'h0300, 2, 0, 4'h0, 0, 0, 0, 0, 16'h0222);
    step("rel",    B0,  0, 4'h0, 16'h0300, 2, 0, 4'h0, 0, 0, 0, 0, 16'h0222);
    step("ss_run2",BSS, 0, 4'h0, 16'h0300, 1, 0, 4'h0, 0, 0, 0, 0, 16'h0222);
    step("tk_pre", B0,  1, 4'h0, 16'h0300, 1, 0, 4'h1, 0, 0, 0, 0, 16'h0222);

    #2;
    btn_ss = 1'b1;
    rst_n  = 1'b0;
    #1;
    push("rst_mid", 0, 0, 0, 0, 0, 0, 0, 16'h0300);
    pop_check();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    step("held1",  BSS, 0, 4'h0, 16'h0300, 0, 0, 4'h0, 0, 0, 0, 0, 16'h0300);
    step("held2",  BSS, 0, 4'h0, 16'h0300, 0, 0, 4'h0, 0, 0, 0, 0, 16'h0300);
    step("held3",  BSS, 0, 4'h0, 16'h0300, 0, 0, 4'h0, 0, 0, 0, 0, 16'h0300);
    step("rel",    B0,  0, 4'h0, 16'h0300, 0, 0, 4'h0, 0, 0, 0, 0, 16'h0300);
    step("ss_aft", BSS, 0, 4'h0, 16'h0300, 1, 0, 4'h0, 0, 0, 0, 0, 16'h0300);

    if (sb.size() != 0) begin
      ntot++;
      nfail++;
      $display("FAIL sb_left got %0d exp 0", sb.size());
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter SEC_TENS_MAX, default 5, giving the terminal value of the seconds-tens digit.
REQ-002 SHALL have parameter MIN_TENS_MAX, default 5, giving the terminal value of the minutes-tens digit; units digits always terminate at 9.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all logic on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port tick, input, 1 bit: one-cycle 1 Hz time-base pulse.
REQ-006 SHALL have ports btn_ss, btn_lap, btn_clr, btn_mode and btn_inc, input, 1 bit each: synchronized, debounced button levels.
REQ-007 SHALL have port tc, input, 4 bits: per-digit terminal-count flags, with [0] seconds units, [1] seconds tens, [2] minutes units and [3] minutes tens.
REQ-008 SHALL have port bcd_in, input, 16 bits: current counter digits, {mt,mu,st,su}, 4 bits each.
REQ-009 SHALL have port cnt_en, output, 4 bits: per-digit advance strobes.
REQ-010 SHALL have port load, output, 4 bits: per-digit load strobes.
REQ-011 SHALL have port load_val, output, 4 bits: value for the digit being loaded.
REQ-012 SHALL have port clear, output, 1 bit: clear-all-digits strobe.
REQ-013 SHALL have port disp, output, 16 bits: digits to display.
REQ-014 SHALL have port sel, output, 4 bits: one-hot digit selected in SET, else 0.
REQ-015 SHALL have port state, output, 2 bits: current FSM state.
REQ-016 SHALL have port ovf, output, 1 bit: sticky wrap-past-59:59 flag.

Function
REQ-017 SHALL detect a button press as input high with its registered previous sample low; at most one press SHALL be acted on per cycle.
REQ-018 Simultaneous presses SHALL be resolved with priority clr > mode > ss > lap > inc; lower-priority presses in the same cycle SHALL be discarded.
REQ-019 SHALL implement FSM states IDLE=0, RUN=1, PAUSE=2 and SET=3.
REQ-020 IDLE: ss -> RUN; mode -> SET with sel=0001; clr -> clear strobe, stay IDLE.
REQ-021 RUN: ss -> PAUSE; lap toggles lap_hold; clr and mode ignored.
REQ-022 PAUSE: ss -> RUN; clr -> clear strobe, IDLE, lap_hold=0, ovf=0; mode -> SET with sel=0001.
REQ-023 SET: mode rotates sel 0001->0010->0100->1000; mode with sel=1000 -> PAUSE with sel=0.
REQ-024 SET: inc -> load[k]=1 for selected digit k, with load_val = bcd_in digit k + 1, or 0 if that digit equals its terminal value.
REQ-025 SET: clr -> clear strobe, IDLE, sel=0; ss ignored.
REQ-026 RUN: on tick, cnt_en[0]=1 and cnt_en[i]=1 for i>0 iff tc[0..i-1] all 1, sampled in the tick cycle.
REQ-027 RUN: tick with tc=1111 SHALL set ovf and keep running; counters wrap to 00:00.
REQ-028 SHALL assert no cnt_en outside RUN; ticks there SHALL be dropped, not queued.
REQ-029 All strobes (cnt_en, load, clear) SHALL be registered: high for exactly one cycle, beginning the cycle after the triggering press or tick.
REQ-030 State, sel and lap_hold SHALL update on the same edge that registers the strobes.
REQ-031 lap_hold rising SHALL capture bcd_in into lap_reg; disp = lap_hold ? lap_reg : bcd_in.
REQ-032 Leaving RUN SHALL NOT clear lap_hold; only clr or reset clears it.
REQ-033 load, cnt_en and clear SHALL be mutually exclusive in any cycle.

Reset
REQ-034 On rst_n low, state=IDLE, with cnt_en, load, load_val, clear, sel, ovf, lap_hold and lap_reg all 0, and button history registers 0.
REQ-035 disp SHALL equal bcd_in during reset.
REQ-036 Reset asserted mid-strobe SHALL drop the strobe immediately.
REQ-037 A button held high through reset release SHALL NOT register a press.

Structure
REQ-038 A shared package SHALL hold the state enum (sw_state_t), digit index constants and UNIT_MAX=9.
REQ-039 The button edge detector SHALL be one sub-module, sw_btn_edge, instantiated once per button.
REQ-040 The carry cascade and SET load logic SHALL stay in stopwatch_ctrl.

Verification
REQ-041 IDLE, ss press, tick with tc=0000 -> state=RUN, cnt_en=0001 one cycle after tick.
REQ-042 RUN, tick with tc=0111 -> cnt_en=1111; tc=1111 -> cnt_en=1111 and ovf=1, still RUN.
REQ-043 PAUSE, mode, then inc with bcd_in digit0=9 -> sel=0001, load=0001, load_val=0; four mode presses -> PAUSE, sel=0.
REQ-044 RUN, lap with bcd_in=0x0123, then bcd_in=0x0130 -> disp=0x0123; second lap -> disp=0x0130.
REQ-045 PAUSE, clr and ss pressed in the same cycle -> clear pulse, state=IDLE, no RUN.
REQ-046 RUN with lap_hold=1, rst_n low mid-cycle -> all outputs 0 immediately; btn_ss held across release -> stays IDLE.
